mem_stage: RTL and testbench

- MEM pipeline stage between EX and WB.
- Accepts one instruction per handshake from EX and waits for the data-SRAM response of any load or store request EX issued.
- Extracts and sign/zero-extends load data, forwards result, exception and TLB bundles to WB, and exposes bypass/blocking info to ID and EX.
- Discards stale data-SRAM responses belonging to flushed instructions.

---
 rtl/mem_stage_pkg.sv | 16 +
 rtl/mem_stage_load_align.sv | 20 ++
 rtl/mem_stage.sv | 144 ++++++++++++++
 tb/tb_mem_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants for the MEM stage (load-op encoding, bundle widths, exception flag positions)
package mem_stage_pkg;
  localparam int EX_ZIP_W_DEF = 87;
  localparam int TLB_ZIP_W_DEF = 10;
  localparam int TLB_EXC_W_DEF = 8;
  localparam int LD_OP_W = 5;
  localparam int LD_B = 0;
  localparam int LD_BU = 1;
  localparam int LD_H = 2;
  localparam int LD_HU = 3;
  localparam int LD_W = 4;
  // ex_zip[6:0] are exception flags; ertn and refetch markers sit just above them
  localparam int EXC_FLAGS_W = 7;
  localparam int EZ_ERTN = 7;
  localparam int EZ_REFETCH = 8;
endpackage

// File: rtl/mem_stage_load_align.sv
// mem_load_align: byte/half select and sign/zero extension of load data
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0]        rdata,
  input  logic [1:0]         addr,
  input  logic [LD_OP_W-1:0] ld_op,
  output logic [31:0]        data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    data = ld_op[LD_B]  ? {{24{b[7]}}, b} :
           ld_op[LD_BU] ? {24'b0, b} :
           ld_op[LD_H]  ? {{16{h[15]}}, h} :
           ld_op[LD_HU] ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; waits on data-SRAM responses, aligns loads,
// and drops responses owed to flushed instructions via a small counter.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int EX_ZIP_W  = EX_ZIP_W_DEF,
  parameter int TLB_ZIP_W = TLB_ZIP_W_DEF,
  parameter int TLB_EXC_W = TLB_EXC_W_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  output logic                 ms_allowin,
  input  logic                 es_to_ms_valid,
  input  logic [31:0]          es_pc,
  input  logic [31:0]          es_result,
  input  logic [4:0]           es_rf_waddr,
  input  logic                 es_rf_we,
  input  logic                 es_mem_req,
  input  logic [LD_OP_W-1:0]   es_ld_op,
  input  logic                 es_csr_re,
  input  logic [EX_ZIP_W-1:0]  es_ex_zip,
  input  logic [TLB_ZIP_W-1:0] es_tlb_zip,
  input  logic [TLB_EXC_W-1:0] es_tlb_exc,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 ws_allowin,
  input  logic                 wb_ex,
  input  logic                 ertn_flush,
  input  logic                 wb_refetch_flush,
  output logic                 ms_to_ws_valid,
  output logic [31:0]          ms_pc,
  output logic [31:0]          ms_rf_wdata,
  output logic [4:0]           ms_rf_waddr,
  output logic                 ms_rf_we,
  output logic                 ms_csr_re,
  output logic [31:0]          ms_result,
  output logic [EX_ZIP_W-1:0]  ms_ex_zip,
  output logic [TLB_ZIP_W-1:0] ms2ws_tlb_zip,
  output logic [TLB_EXC_W-1:0] ms2ws_tlb_exc,
  output logic                 ms_fwd_we,
  output logic [4:0]           ms_fwd_waddr,
  output logic [31:0]          ms_fwd_wdata,
  output logic                 ms_ld_block,
  output logic                 ms_ex_block
);
  logic                 ms_valid_q, ms_valid_d;
  logic [31:0]          pc_q, pc_d, result_q, result_d;
  logic [4:0]           waddr_q, waddr_d;
  logic                 we_q, we_d, mem_req_q, mem_req_d, csr_re_q, csr_re_d;
  logic [LD_OP_W-1:0]   ld_op_q, ld_op_d;
  logic [EX_ZIP_W-1:0]  ex_zip_q, ex_zip_d;
  logic [TLB_ZIP_W-1:0] tlb_zip_q, tlb_zip_d;
  logic [TLB_EXC_W-1:0] tlb_exc_q, tlb_exc_d;
  logic                 buf_valid_q, buf_valid_d;
  logic [31:0]          buf_data_q, buf_data_d;
  logic [1:0]           drop_cnt_q, drop_cnt_d;
  logic                 flush, has_exc, data_ok_use, ready_go, accept, moves, buf_set;
  logic [2:0]           drop_sum;
  logic [31:0]          load_data;
  mem_load_align u_align (
    .rdata(buf_valid_q ? buf_data_q : data_sram_rdata),
    .addr (result_q[1:0]),
    .ld_op(ld_op_q),
    .data (load_data)
  );
  always_comb begin
    flush = wb_ex | ertn_flush | wb_refetch_flush;
    has_exc = (|ex_zip_q[EXC_FLAGS_W-1:0]) | (|tlb_exc_q);
    data_ok_use = data_sram_data_ok & (drop_cnt_q == 2'd0);
    ready_go = ~mem_req_q | has_exc | buf_valid_q | data_ok_use;
    ms_allowin = ~ms_valid_q | (ready_go & ws_allowin);
    accept = es_to_ms_valid & ms_allowin;
    moves = ms_valid_q & ready_go & ws_allowin;
    ms_valid_d = flush ? 1'b0 : ms_allowin ? es_to_ms_valid : ms_valid_q;
    pc_d = accept ? es_pc : pc_q;
    result_d = accept ? es_result : result_q;
    waddr_d = accept ? es_rf_waddr : waddr_q;
    we_d = accept ? es_rf_we : we_q;
    mem_req_d = accept ? es_mem_req : mem_req_q;
    ld_op_d = accept ? es_ld_op : ld_op_q;
    csr_re_d = accept ? es_csr_re : csr_re_q;
    ex_zip_d = accept ? es_ex_zip : ex_zip_q;
    tlb_zip_d = accept ? es_tlb_zip : tlb_zip_q;
    tlb_exc_d = accept ? es_tlb_exc : tlb_exc_q;
    // hold a consumed response while WB stalls so it is not waited for again
    buf_set = ms_valid_q & mem_req_q & ~buf_valid_q & data_ok_use & ~ws_allowin;
    buf_valid_d = (flush | moves) ? 1'b0 : buf_set ? 1'b1 : buf_valid_q;
    buf_data_d = buf_set ? data_sram_rdata : buf_data_q;
    // responses still owed to flushed requests, in arrival order ahead of any new one
    drop_sum = {1'b0, drop_cnt_q}
             + (flush ? {2'b0, ms_valid_q & mem_req_q & ~buf_valid_q & ~data_ok_use} : 3'd0)
             + (flush ? {2'b0, accept & es_mem_req} : 3'd0)
             - {2'b0, data_sram_data_ok & (drop_cnt_q != 2'd0)};
    drop_cnt_d = (drop_sum > 3'd3) ? 2'd3 : drop_sum[1:0];
    ms_to_ws_valid = ms_valid_q & ready_go & ~flush;
    ms_rf_wdata = (|ld_op_q) ? load_data : result_q;
    ms_fwd_we = ms_valid_q & we_q & ~csr_re_q;
    ms_fwd_waddr = waddr_q;
    ms_fwd_wdata = ms_rf_wdata;
    ms_ld_block = ms_valid_q & (|ld_op_q) & ~ready_go;
    ms_ex_block = ms_valid_q & (has_exc | ex_zip_q[EZ_ERTN] | ex_zip_q[EZ_REFETCH]);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid_q <= 1'b0;
      pc_q <= '0;
      result_q <= '0;
      waddr_q <= '0;
      we_q <= 1'b0;
      mem_req_q <= 1'b0;
      ld_op_q <= '0;
      csr_re_q <= 1'b0;
      ex_zip_q <= '0;
      tlb_zip_q <= '0;
      tlb_exc_q <= '0;
      buf_valid_q <= 1'b0;
      buf_data_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      ms_valid_q <= ms_valid_d;
      pc_q <= pc_d;
      result_q <= result_d;
      waddr_q <= waddr_d;
      we_q <= we_d;
      mem_req_q <= mem_req_d;
      ld_op_q <= ld_op_d;
      csr_re_q <= csr_re_d;
      ex_zip_q <= ex_zip_d;
      tlb_zip_q <= tlb_zip_d;
      tlb_exc_q <= tlb_exc_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q <= buf_data_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign ms_pc = pc_q;
  assign ms_result = result_q;
  assign ms_rf_waddr = waddr_q;
  assign ms_rf_we = we_q;
  assign ms_csr_re = csr_re_q;
  assign ms_ex_zip = ex_zip_q;
  assign ms2ws_tlb_zip = tlb_zip_q;
  assign ms2ws_tlb_exc = tlb_exc_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_allowin, es_to_ms_valid, es_rf_we, es_mem_req, es_csr_re;
  logic [31:0] es_pc, es_result, data_sram_rdata;
  logic [4:0]  es_rf_waddr, es_ld_op;
  logic [86:0] es_ex_zip;
  logic [9:0]  es_tlb_zip;
  logic [7:0]  es_tlb_exc;
  logic        data_sram_data_ok, ws_allowin, wb_ex, ertn_flush, wb_refetch_flush;
  logic        ms_to_ws_valid, ms_rf_we, ms_csr_re, ms_fwd_we, ms_ld_block, ms_ex_block;
  logic [31:0] ms_pc, ms_rf_wdata, ms_result, ms_fwd_wdata;
  logic [4:0]  ms_rf_waddr, ms_fwd_waddr;
  logic [86:0] ms_ex_zip;
  logic [9:0]  ms2ws_tlb_zip;
  logic [7:0]  ms2ws_tlb_exc;
  typedef struct {logic [31:0] pc; logic [31:0] wdata; logic [4:0] waddr; logic we;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [86:0] exz;
  mem_stage dut (
    .clk(clk), .resetn(resetn), .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid),
    .es_pc(es_pc), .es_result(es_result), .es_rf_waddr(es_rf_waddr), .es_rf_we(es_rf_we),
    .es_mem_req(es_mem_req), .es_ld_op(es_ld_op), .es_csr_re(es_csr_re), .es_ex_zip(es_ex_zip),
    .es_tlb_zip(es_tlb_zip), .es_tlb_exc(es_tlb_exc), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .ws_allowin(ws_allowin), .wb_ex(wb_ex),
    .ertn_flush(ertn_flush), .wb_refetch_flush(wb_refetch_flush), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_pc(ms_pc), .ms_rf_wdata(ms_rf_wdata), .ms_rf_waddr(ms_rf_waddr), .ms_rf_we(ms_rf_we),
    .ms_csr_re(ms_csr_re), .ms_result(ms_result), .ms_ex_zip(ms_ex_zip),
    .ms2ws_tlb_zip(ms2ws_tlb_zip), .ms2ws_tlb_exc(ms2ws_tlb_exc), .ms_fwd_we(ms_fwd_we),
    .ms_fwd_waddr(ms_fwd_waddr), .ms_fwd_wdata(ms_fwd_wdata), .ms_ld_block(ms_ld_block),
    .ms_ex_block(ms_ex_block)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] pc, input logic [31:0] wd, input logic [4:0] wa, input logic we);
    exp_t e;
    e.pc = pc; e.wdata = wd; e.waddr = wa; e.we = we;
    q.push_back(e);
  endtask
  task automatic send(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] wa,
                      input logic we, input logic mr, input logic [4:0] ld,
                      input logic [86:0] ez, input logic [7:0] te);
    es_to_ms_valid = 1'b1; es_pc = pc; es_result = res; es_rf_waddr = wa; es_rf_we = we;
    es_mem_req = mr; es_ld_op = ld; es_ex_zip = ez; es_tlb_exc = te; es_tlb_zip = pc[9:0];
    #1;
    for (int i = 0; i < 20 && !ms_allowin; i++) step();
    chk("send_allowin", ms_allowin, 1);
    step();
    es_to_ms_valid = 1'b0; es_mem_req = 1'b0; es_ld_op = '0; es_ex_zip = '0; es_tlb_exc = '0;
  endtask
  // leaves two responses owed: one from a flushed in-flight load, one from a load accepted during a flush
  task automatic drop2();
    send(32'h500, 32'h5000, 5'd3, 1'b1, 1'b1, 5'b10000, '0, '0);
    wb_ex = 1'b1;
    #1 chk("flush_no_wb", ms_to_ws_valid, 0);
    step();
    es_to_ms_valid = 1'b1; es_mem_req = 1'b1; es_ld_op = 5'b10000;
    #1 chk("flush_accept_allowin", ms_allowin, 1);
    step();
    wb_ex = 1'b0; es_to_ms_valid = 1'b0; es_mem_req = 1'b0; es_ld_op = '0;
  endtask
  always @(negedge clk) begin
    if (resetn && ms_to_ws_valid && ws_allowin) begin
      if (q.size() == 0) begin
        chk("wb_unexpected_pc", ms_pc, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_pc", ms_pc, e.pc);
        chk("wb_wdata", ms_rf_wdata, e.wdata);
        chk("wb_waddr", ms_rf_waddr, e.waddr);
        chk("wb_we", ms_rf_we, e.we);
      end
    end
  end
  initial begin
    resetn = 1'b0; es_to_ms_valid = 1'b0; es_pc = '0; es_result = '0; es_rf_waddr = '0;
    es_rf_we = 1'b0; es_mem_req = 1'b0; es_ld_op = '0; es_csr_re = 1'b0; es_ex_zip = '0;
    es_tlb_zip = '0; es_tlb_exc = '0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    ws_allowin = 1'b1; wb_ex = 1'b0; ertn_flush = 1'b0; wb_refetch_flush = 1'b0;
    step(); step();
    chk("rst_allowin", ms_allowin, 1);
    chk("rst_valid", ms_to_ws_valid, 0);
    chk("rst_pc", ms_pc, 0);
    resetn = 1'b1;
    // ld_b, top byte 0x80 sign-extends
    send(32'h100, 32'h1003, 5'd5, 1'b1, 1'b1, 5'b00001, '0, '0);
    push(32'h100, 32'hFFFF_FF80, 5'd5, 1'b1);
    #1 chk("ldb_block1", ms_ld_block, 1);
    step();
    #1 chk("ldb_block2", ms_ld_block, 1);
    step();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8011_2233;
    #1 chk("ldb_block3", ms_ld_block, 0);
    chk("ldb_valid", ms_to_ws_valid, 1);
    step();
    data_sram_data_ok = 1'b0;
    #1 chk("ldb_one_cycle", ms_to_ws_valid, 0);
    // ld_hu buffered across a 3-cycle WB stall
    send(32'h200, 32'h2002, 5'd6, 1'b1, 1'b1, 5'b01000, '0, '0);
    push(32'h200, 32'h0000_8001, 5'd6, 1'b1);
    ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_ABCD;
    step();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'hDEAD_BEEF;
    #1 chk("ldhu_hold_valid", ms_to_ws_valid, 1);
    chk("ldhu_hold_data", ms_rf_wdata, 32'h0000_8001);
    step();
    #1 chk("ldhu_hold_block", ms_ld_block, 0);
    step();
    ws_allowin = 1'b1;
    step();
    #1 chk("ldhu_gone", ms_to_ws_valid, 0);
    // plain ALU result, bypass visible
    send(32'h300, 32'h1234_5678, 5'd7, 1'b1, 1'b0, 5'b00000, '0, '0);
    push(32'h300, 32'h1234_5678, 5'd7, 1'b1);
    #1 chk("add_fwd_we", ms_fwd_we, 1);
    chk("add_fwd_wdata", ms_fwd_wdata, 32'h1234_5678);
    chk("add_fwd_waddr", ms_fwd_waddr, 7);
    chk("add_valid", ms_to_ws_valid, 1);
    step();
    // sys exception, no memory request
    exz = 87'h2A_BCDE_F012_3456_7890_0001;
    send(32'h400, 32'h44, 5'd8, 1'b1, 1'b0, 5'b00000, exz, '0);
    push(32'h400, 32'h44, 5'd8, 1'b1);
    #1 chk("exc_ex_block", ms_ex_block, 1);
    chk("exc_zip", ms_ex_zip, exz);
    chk("exc_valid", ms_to_ws_valid, 1);
    step();
    // two stale responses dropped, third delivered
    drop2();
    send(32'h600, 32'h6004, 5'd9, 1'b1, 1'b1, 5'b10000, '0, '0);
    push(32'h600, 32'hCAFE_F00D, 5'd9, 1'b1);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
    #1 chk("drop1_hidden", ms_to_ws_valid, 0);
    step();
    data_sram_rdata = 32'h2222_2222;
    #1 chk("drop2_hidden", ms_to_ws_valid, 0);
    step();
    data_sram_rdata = 32'hCAFE_F00D;
    #1 chk("drop_third_valid", ms_to_ws_valid, 1);
    step();
    data_sram_data_ok = 1'b0;
    // TLB exception with a request: ready at once, its response dropped after flush
    send(32'h800, 32'h8000, 5'd10, 1'b1, 1'b1, 5'b10000, '0, 8'h04);
    ws_allowin = 1'b0;
    #1 chk("tlbexc_ready", ms_to_ws_valid, 1);
    chk("tlbexc_ex_block", ms_ex_block, 1);
    chk("tlbexc_ld_block", ms_ld_block, 0);
    step();
    wb_ex = 1'b1;
    step();
    wb_ex = 1'b0; ws_allowin = 1'b1;
    send(32'h900, 32'h9002, 5'd11, 1'b1, 1'b1, 5'b00100, '0, '0);
    push(32'h900, 32'hFFFF_8000, 5'd11, 1'b1);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hFFFF_0000;
    #1 chk("tlbexc_drop_hidden", ms_to_ws_valid, 0);
    step();
    data_sram_rdata = 32'h8000_1234;
    step();
    data_sram_data_ok = 1'b0;
    // reset with responses owed and an instruction resident
    drop2();
    send(32'h700, 32'h7000, 5'd12, 1'b1, 1'b1, 5'b10000, '0, '0);
    chk("pre_rst_busy", ms_allowin, 0);
    resetn = 1'b0;
    step();
    chk("rst2_allowin", ms_allowin, 1);
    chk("rst2_valid", ms_to_ws_valid, 0);
    chk("rst2_pc", ms_pc, 0);
    chk("rst2_wdata", ms_rf_wdata, 0);
    chk("rst2_we", ms_rf_we, 0);
    chk("rst2_ld_block", ms_ld_block, 0);
    chk("rst2_fwd_we", ms_fwd_we, 0);
    resetn = 1'b1;
    send(32'h780, 32'h7001, 5'd13, 1'b1, 1'b1, 5'b00010, '0, '0);
    push(32'h780, 32'h0000_00AB, 5'd13, 1'b1);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_AB00;
    #1 chk("post_rst_valid", ms_to_ws_valid, 1);
    step();
    data_sram_data_ok = 1'b0;
    step(); step();
    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
